// File: rtl/s74194_seq_ctrl.sv
// s74194_seq_ctrl
//   Sequencer for one s74194 bidirectional universal shift register. Accepts a
//   word over a valid/ready handshake, parallel-loads it into the register,
//   then issues WIDTH shifts in the direction sampled at the handshake and
//   captures the register's parallel output as the received word. Together
//   with the register this forms a full-duplex serialise/deserialise engine.
//
//   Optional build macro: SR_CTRL_ROTATE_EN adds the rotate input; when it was
//   high at the handshake the register's serial output is fed back into its
//   serial input, so the transfer rotates the word through the register.
//
// Parameters
//   WIDTH       register width and number of shifts per transfer
//   GAP_CYCLES  idle cycles inserted after each transfer before tx_ready
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous active-low reset
//   tx_data/valid/ready word to send (handshake accepted in IDLE only)
//   dir                 0 = shift right, 1 = shift left (sampled at handshake)
//   shift_en            0 pauses shifting (register held)
//   ser_in              external serial stream for the register
//   rotate              rotate through the register (SR_CTRL_ROTATE_EN only)
//   sr_mode/pin/sin     drive the s74194 mode, parallel and serial inputs
//   sr_sout/pout        s74194 serial and parallel outputs
//   rx_data/rx_valid    captured word and its one-cycle strobe
//   busy                high whenever a transfer or gap is in progress
module s74194_seq_ctrl #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic             dir,
    input  logic             shift_en,
    input  logic             ser_in,
`ifdef SR_CTRL_ROTATE_EN
    input  logic             rotate,
`endif
    output logic [1:0]       sr_mode,
    output logic [WIDTH-1:0] sr_pin,
    output logic             sr_sin,
    input  logic             sr_sout,
    input  logic [WIDTH-1:0] sr_pout,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    // gap counter runs 0..GAP_CYCLES-1
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
`ifdef SR_CTRL_ROTATE_EN
    logic             rotate_q, rotate_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            gap_q      <= '0;
            data_q     <= '0;
            dir_q      <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
`ifdef SR_CTRL_ROTATE_EN
            rotate_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            gap_q      <= gap_d;
            data_q     <= data_d;
            dir_q      <= dir_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
`ifdef SR_CTRL_ROTATE_EN
            rotate_q   <= rotate_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        gap_d      = gap_q;
        data_d     = data_q;
        dir_d      = dir_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
`ifdef SR_CTRL_ROTATE_EN
        rotate_d   = rotate_q;
`endif
        sr_mode    = MODE_HOLD;
        tx_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    data_d  = tx_data;
                    dir_d   = dir;
`ifdef SR_CTRL_ROTATE_EN
                    rotate_d = rotate;
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sr_mode = MODE_LOAD;
                count_d = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (shift_en) begin
                    sr_mode = dir_q ? MODE_LEFT : MODE_RIGHT;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // register has absorbed the last shift; its contents are final
                rx_data_d  = sr_pout;
                rx_valid_d = 1'b1;
                gap_d      = '0;
                state_d    = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
            GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sr_pin   = data_q;
    assign busy     = (state_q != IDLE);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

`ifdef SR_CTRL_ROTATE_EN
    assign sr_sin = rotate_q ? sr_sout : ser_in;
`else
    assign sr_sin = ser_in;
    logic unused_sout;
    assign unused_sout = sr_sout;
`endif

endmodule

// File: tb/tb_s74194_seq_ctrl.sv
module tb_s74194_seq_ctrl;

    localparam int W   = 8;
    localparam int GAP = 2;

    logic         clk      = 1'b0;
    logic         rst      = 1'b0;
    logic [W-1:0] tx_data  = '0;
    logic         tx_valid = 1'b0;
    logic         dir      = 1'b0;
    logic         shift_en = 1'b1;
    logic         ser_in   = 1'b0;
    logic         rotate   = 1'b0;

    logic         tx_ready;
    logic [1:0]   sr_mode;
    logic [W-1:0] sr_pin;
    logic         sr_sin;
    logic         sr_sout;
    logic [W-1:0] sr_pout;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         busy;

    s74194_seq_ctrl #(
        .WIDTH      (W),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .dir      (dir),
        .shift_en (shift_en),
        .ser_in   (ser_in),
`ifdef SR_CTRL_ROTATE_EN
        .rotate   (rotate),
`endif
        .sr_mode  (sr_mode),
        .sr_pin   (sr_pin),
        .sr_sin   (sr_sin),
        .sr_sout  (sr_sout),
        .sr_pout  (sr_pout),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // External s74194: not reset by the controller
    logic [W-1:0] sreg = '0;
    assign sr_pout = sreg;
    assign sr_sout = (sr_mode == 2'b10) ? sreg[W-1] : sreg[0];
    always @(posedge clk) begin
        case (sr_mode)
            2'b11:   sreg <= sr_pin;
            2'b01:   sreg <= {sr_sin, sreg[W-1:1]};
            2'b10:   sreg <= {sreg[W-2:0], sr_sin};
            default: sreg <= sreg;
        endcase
    end

    // Transfer model: counters of remaining work rather than a state machine
    bit           m_load = 0;
    int           m_sh   = -1;   // shifts done in the current transfer, -1 if not shifting
    bit           m_done = 0;
    int           m_gap  = 0;    // gap cycles still to come
    logic [W-1:0] m_word = '0;
    logic [W-1:0] m_reg  = '0;
    logic [W-1:0] m_rxd  = '0;
    bit           m_dir  = 0;
    bit           m_rot  = 0;
    bit           m_rxv  = 0;

    always @(negedge clk) begin
        bit         idle;
        logic [1:0] e_mode;
        logic       e_out;
        logic       e_sin;
        if (!rst) begin
            m_load = 0; m_sh = -1; m_done = 0; m_gap = 0;
            m_word = '0; m_rxd = '0; m_dir = 0; m_rot = 0; m_rxv = 0;
        end
        idle   = !m_load && (m_sh < 0) && !m_done && (m_gap == 0);
        e_mode = m_load ? 2'b11 : ((m_sh >= 0) && shift_en) ? (m_dir ? 2'b10 : 2'b01) : 2'b00;
        e_out  = (e_mode == 2'b10) ? m_reg[W-1] : m_reg[0];
        e_sin  = m_rot ? e_out : ser_in;

        chk("tx_ready", tx_ready, idle);
        chk("busy", busy, !idle);
        chk("sr_mode", sr_mode, e_mode);
        chk("sr_pin", sr_pin, m_word);
        chk("sr_sin", sr_sin, e_sin);
        chk("rx_data", rx_data, m_rxd);
        chk("rx_valid", rx_valid, m_rxv);

        if (rst) begin
            m_rxv = m_done;
            if (m_done) m_rxd = m_reg;
            if (idle) begin
                if (tx_valid) begin
                    m_word = tx_data;
                    m_dir  = dir;
`ifdef SR_CTRL_ROTATE_EN
                    m_rot  = rotate;
`endif
                    m_load = 1;
                end
            end else if (m_load) begin
                m_load = 0;
                m_reg  = m_word;
                m_sh   = 0;
            end else if (m_sh >= 0) begin
                if (shift_en) begin
                    m_reg = m_dir ? {m_reg[W-2:0], e_sin} : {e_sin, m_reg[W-1:1]};
                    m_sh++;
                    if (m_sh == W) begin
                        m_sh   = -1;
                        m_done = 1;
                    end
                end
            end else if (m_done) begin
                m_done = 0;
                m_gap  = GAP;
            end else if (m_gap > 0) begin
                m_gap--;
            end
        end
    end

    // One transfer: returns rx_valid latency from the handshake, the received
    // word, the first ten sr_mode values after the handshake and how many of
    // those ten cycles had tx_ready low. dir is flipped right after the
    // handshake; shift_en is low for p_len cycles starting at offset p_at.
    task automatic xfer(input logic [W-1:0] w, input bit d, input bit si,
                        input int p_at, input int p_len,
                        output int lat, output logic [W-1:0] rxw,
                        output logic [19:0] mlog, output int rdy_lo);
        int hs;
        bit got;
        lat = -1; rxw = '0; mlog = '0; rdy_lo = 0; got = 0;
        @(posedge clk); #1;
        tx_data = w; dir = d; ser_in = si; tx_valid = 1'b1; shift_en = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (tx_ready) got = 1;
        end
        if (!got) begin
            timeout("handshake");
            tx_valid = 1'b0;
            return;
        end
        hs = cyc;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            tx_valid = 1'b0;
            dir      = ~d;
            shift_en = !(k >= p_at && k < p_at + p_len);
            @(negedge clk);
            if (k <= 10) begin
                mlog = {mlog[17:0], sr_mode};
                if (!tx_ready) rdy_lo++;
            end
            if (rx_valid) begin
                lat = cyc - hs;
                rxw = rx_data;
                break;
            end
        end
        shift_en = 1'b1;
        if (lat < 0) timeout("rx_valid");
    endtask

    task automatic wait_idle();
        bit got;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (tx_ready) got = 1;
        end
        if (!got) timeout("idle");
    endtask

    initial begin
        int           lat;
        int           rdy_lo;
        int           h1;
        int           h2;
        int           lo;
        int           pulses;
        bit           got;
        logic [W-1:0] rxw;
        logic [19:0]  mlog;
        logic [7:0]   pat;
        pat = 8'b1011_0010;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset sr_mode", sr_mode, 2'b00);
        chk("reset busy", busy, 1'b0);
        chk("reset tx_ready", tx_ready, 1'b1);
        chk("reset rx_valid", rx_valid, 1'b0);
        chk("reset rx_data", rx_data, 8'h00);
        @(posedge clk); #2;
        rst = 1'b1;

        // right shift filling with ones
        xfer(8'h3C, 1'b0, 1'b1, 0, 0, lat, rxw, mlog, rdy_lo);
        chk("t1 latency", lat, 11);
        chk("t1 rx_data", rxw, 8'hFF);
        chk("t1 modes", mlog, 20'hD5554);

        // left shift filling with zeros
        xfer(8'hA5, 1'b1, 1'b0, 0, 0, lat, rxw, mlog, rdy_lo);
        chk("t2 latency", lat, 11);
        chk("t2 rx_data", rxw, 8'h00);
        chk("t2 modes", mlog, 20'hEAAA8);
        chk("t2 tx_ready low 1..10", rdy_lo, 10);

        // pause of three cycles after the fourth shift
        xfer(8'h3C, 1'b0, 1'b1, 6, 3, lat, rxw, mlog, rdy_lo);
        chk("t3 latency", lat, 14);
        chk("t3 rx_data", rxw, 8'hFF);
        chk("t3 modes", mlog, 20'hD5405);

        // back-to-back words with tx_valid held high
        wait_idle();
        @(posedge clk); #1;
        tx_data = 8'h1A; dir = 1'b0; tx_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (tx_ready) got = 1;
        end
        if (!got) timeout("b2b first handshake");
        h1 = cyc; h2 = -1; lo = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            tx_data = 8'h2B;
            ser_in  = pat[k % 8];
            @(negedge clk);
            if (tx_ready) begin
                h2 = cyc;
                break;
            end
            lo++;
        end
        chk("b2b handshake spacing", h2 - h1, 13);
        chk("b2b tx_ready low", lo, 12);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(posedge clk); #1;
            ser_in = pat[i % 8];
            @(negedge clk);
            if (rx_valid) got = 1;
        end
        if (!got) timeout("b2b second rx_valid");

        // asynchronous reset after three shifts
        wait_idle();
        @(posedge clk); #1;
        tx_data = 8'hC3; dir = 1'b0; ser_in = 1'b0; tx_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (tx_ready) got = 1;
        end
        if (!got) timeout("reset test handshake");
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async rst sr_mode", sr_mode, 2'b00);
        chk("async rst busy", busy, 1'b0);
        chk("async rst tx_ready", tx_ready, 1'b1);
        chk("async rst sr_pin", sr_pin, 8'h00);
        @(posedge clk); #2;
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rx_valid) pulses++;
        end
        chk("no rx_valid after reset", pulses, 0);
        xfer(8'h35, 1'b0, 1'b1, 0, 0, lat, rxw, mlog, rdy_lo);
        chk("post-reset latency", lat, 11);
        chk("post-reset rx_data", rxw, 8'hFF);

`ifdef SR_CTRL_ROTATE_EN
        rotate = 1'b1;
        xfer(8'h96, 1'b0, 1'b0, 0, 0, lat, rxw, mlog, rdy_lo);
        chk("rotate right rx_data", rxw, 8'h96);
        xfer(8'h96, 1'b1, 1'b1, 0, 0, lat, rxw, mlog, rdy_lo);
        chk("rotate left rx_data", rxw, 8'h96);
        rotate = 1'b0;
`endif

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/s74194_seq_ctrl.md
Name: s74194_seq_ctrl

Overview:
- Sequencer for the 8-bit bidirectional universal shift register (s74194) datapath.
- Accepts a parallel word over a valid/ready handshake and drives the register's mode, parallel-input and serial-input pins: one parallel load, then WIDTH shifts in the selected direction.
- Captures the register's parallel output as the received word, so it works as a full-duplex serialise/deserialise engine.
- Sits between a byte-level producer/consumer and one s74194 instance.

Parameters:
- WIDTH, 8, shift register width; also the number of shifts per transfer.
- GAP_CYCLES, 0, hold cycles inserted after each transfer before the next tx_ready.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- tx_data  in  WIDTH  word to load.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  controller can accept a word.
- dir  in  1  0 = shift right (mode 01), 1 = shift left (mode 10); sampled at handshake.
- shift_en  in  1  0 pauses shifting (register held).
- ser_in  in  1  external serial stream fed to the register.
- sr_mode  out  2  to s74194 mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sr_pin  out  WIDTH  to s74194 pin.
- sr_sin  out  1  to s74194 sin.
- sr_sout  in  1  from s74194 sout.
- sr_pout  in  WIDTH  from s74194 pout.
- rx_data  out  WIDTH  captured register contents after a transfer.
- rx_valid  out  1  one-cycle pulse, rx_data updated.
- busy  out  1  high in any state other than IDLE.
- rotate  in  1  present only with SR_CTRL_ROTATE_EN.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, count 0, data_q 0, rx_data 0, rx_valid 0, busy 0, sr_mode 00.
  - Reset mid-transfer aborts the transfer; no rx_valid is produced.
  - The s74194 is not reset by this block.
- sr_mode, sr_pin and busy are decoded combinationally from the registered state. sr_pin = data_q in all states.
- Without the macro, sr_sin = ser_in, combinational.
- IDLE: sr_mode 00, tx_ready 1.
  - On tx_valid & tx_ready: data_q <= tx_data, dir_q <= dir, go to LOAD.
- LOAD (1 cycle): sr_mode 11, tx_ready 0. Go to SHIFT with count 0.
- SHIFT:
  - shift_en = 1: sr_mode = dir_q ? 10 : 01, count increments. At count == WIDTH-1 go to DONE.
  - shift_en = 0: sr_mode 00; count and state hold, with no limit on pause length.
- DONE (1 cycle): sr_mode 00.
  - At the closing edge: rx_data <= sr_pout, rx_valid <= 1.
  - Go to GAP if GAP_CYCLES > 0, else IDLE.
- GAP: sr_mode 00, tx_ready 0. Stay exactly GAP_CYCLES cycles, then IDLE.
- rx_valid is high for exactly one cycle; there is no backpressure, and the consumer must take it.
- Latency (GAP_CYCLES = 0, shift_en held 1), cycle 0 = handshake:
  - LOAD in cycle 1; SHIFT in cycles 2..WIDTH+1; DONE in cycle WIDTH+2.
  - rx_valid and tx_ready are both high in cycle WIDTH+3.
  - Back-to-back throughput is one word per WIDTH+3 cycles.
- tx_valid outside IDLE is ignored; the word is not consumed.
- A dir change after the handshake has no effect until the next word.
- count width = clog2(WIDTH)+1; there is no wrap within a transfer.

Optional Feature:
- Macro SR_CTRL_ROTATE_EN.
- Defined:
  - Port rotate exists.
  - rotate is sampled into rotate_q at the handshake.
  - When rotate_q = 1, sr_sin = sr_sout, so the register rotates and rx_data equals the loaded word after WIDTH shifts.
  - When rotate_q = 0, sr_sin = ser_in.
- Undefined: rotate port absent, sr_sin = ser_in always, sr_sout unused.

Test Plan:
- Single transfer, ser_in = 1, dir 0, tx_data 0x3C -> sr_mode sequence 11 then eight 01 then 00; rx_data 0xFF; rx_valid pulses in cycle 11 after the handshake.
- Same with ser_in = 0, dir 1, tx_data 0xA5 -> eight cycles of sr_mode 10; rx_data 0x00; tx_ready low for cycles 1..10.
- Pause: shift_en low for 3 cycles after the 4th shift -> sr_mode 00 during the pause; rx_valid delayed to cycle 14; rx_data unchanged vs. the unpaused run.
- Back-to-back words 0x1A, 0x2B with tx_valid held high, GAP_CYCLES = 2 -> second handshake exactly 13 cycles after the first; tx_valid ignored while busy.
- Async reset asserted mid-SHIFT (after 3 shifts) -> sr_mode 00, busy 0, tx_ready 1 immediately; no rx_valid; a fresh 0x35 transfer then completes normally.
- With SR_CTRL_ROTATE_EN, rotate = 1, tx_data 0x96, each dir -> rx_data 0x96 for both directions.
